cluster_readout_serializer: RTL
===============================

Name: cluster_readout_serializer

Overview:
- Reads back a 768-bit valid-pattern-flag (VPF) vector, the same vector the cluster counter sums.
- Emits the strip address of each set flag, lowest index first, one per accepted transfer over a valid/ready stream.
- Caps output at MAX_CLUSTERS addresses and flags overflow when set flags remain after the cap.
- Sits after the VPF generation stage, on clock4x, in parallel with the cluster counter.

Parameters:
- NVPF, 768, width of the VPF vector.
- ADDR_W, 10, address width; must satisfy 2^ADDR_W >= NVPF.
- CNT_W, 11, width of the sent-address counter.
- MAX_CLUSTERS, 16, maximum addresses emitted per event; legal range 1..NVPF.
- NSEG, 8, number of priority-encode segments; NVPF/NSEG must be an integer.

Ports:
- clock4x  in  1  sole clock.
- reset_n  in  1  asynchronous active-low reset.
- vpfs_i  in  NVPF  VPF vector; sampled only on an accepted load.
- load_i  in  1  one-cycle start strobe for a new event.
- busy_o  out  1  high from the cycle after an accepted load until the cycle after done_o.
- addr_o  out  ADDR_W  address of the current set flag.
- valid_o  out  1  addr_o is valid.
- ready_i  in  1  downstream accepts addr_o.
- last_o  out  1  current addr_o is the final address of the event.
- sent_cnt_o  out  CNT_W  number of addresses accepted in the current or most recent event.
- overflow_o  out  1  set flags remained after MAX_CLUSTERS were sent; sticky until the next accepted load.
- done_o  out  1  one-cycle pulse at the end of an event.

Behaviour:
- Reset:
  - Reset is asynchronous, active-low, and applies to all flops.
  - FSM goes to IDLE.
  - All outputs go to 0: addr_o=0, valid_o=0, last_o=0, busy_o=0, sent_cnt_o=0, overflow_o=0, done_o=0.
  - The mask register clears to 0.
  - Reset asserted mid-event drops valid_o immediately; the partial event is discarded with no done_o.
- FSM states: IDLE, LOAD, SCAN, DONE.
- IDLE:
  - load_i=1 captures vpfs_i into the mask register, clears sent_cnt_o and overflow_o, and moves to LOAD.
  - load_i is ignored in every state other than IDLE.
- LOAD:
  - Registered segmented priority encode. Each of NSEG segments finds its lowest set bit; the lowest non-empty segment wins.
  - Result goes to addr_o.
  - If the mask is nonzero, valid_o=1 and the FSM moves to SCAN; otherwise it moves to DONE.
- Latency:
  - load_i accepted at cycle N gives valid_o=1 at N+2.
  - An all-zero vector gives done_o=1 at N+2 with no transfer.
- SCAN handshake:
  - Transfer occurs when valid_o && ready_i.
  - While ready_i=0: addr_o, valid_o and last_o hold stable; the mask is unchanged.
  - On transfer: the addressed bit is cleared from the mask and sent_cnt_o increments. The next address, computed from the mask with that bit cleared, is presented in the next cycle.
  - Sustained throughput is one address per cycle while ready_i=1.
- last_o:
  - Asserted with addr_o when the mask holds no other set bit, or when sent_cnt_o == MAX_CLUSTERS-1.
  - Deasserted otherwise.
- Termination: the FSM leaves SCAN for DONE on the transfer that has last_o=1. At that point:
  - valid_o drops next cycle.
  - If set bits remain in the mask, overflow_o is set in the same cycle as the DONE entry.
- DONE:
  - done_o=1 for exactly one cycle, then return to IDLE.
  - busy_o falls in the IDLE cycle.
  - sent_cnt_o and overflow_o hold until the next accepted load.
- Width rules:
  - sent_cnt_o saturates at MAX_CLUSTERS; it never wraps.
  - addr_o is the bit index, 0..NVPF-1.
- Simultaneous events: load_i in the DONE cycle is ignored. A load is accepted only in IDLE, so the earliest back-to-back load is one cycle after done_o.

Test Plan:
- All-zero vpfs_i, load_i at cycle 0 -> no valid_o; done_o=1 at cycle 2; sent_cnt_o=0; overflow_o=0.
- Bits 5, 96, 767 set, ready_i held 1 -> addr_o = 5, 96, 767 on consecutive cycles starting at cycle 2; last_o only with 767; done_o next; sent_cnt_o=3.
- Bits 0..19 set, MAX_CLUSTERS=16 -> addresses 0..15 emitted, last_o with 15, overflow_o=1, sent_cnt_o=16; overflow_o clears on the next load.
- Bits 10 and 11 set; ready_i low for 4 cycles after valid_o -> addr_o=10 held stable 4 cycles; then 10 and 11 transfer on consecutive cycles.
- load_i pulsed while busy (new vector with bit 300 set) -> ignored; the original stream completes unchanged with no address 300.
- reset_n low mid-stream (after 2 of 5 addresses) -> valid_o=0 and busy_o=0 immediately; no done_o; after release, a new load produces the correct full stream.

Source files
------------

// File: rtl/cluster_readout_serializer.sv
// cluster_readout_serializer
// Streams the strip address of every set flag in the VPF vector, lowest index
// first, over a valid/ready interface. Output is capped at MAX_CLUSTERS
// addresses per event; overflow_o marks events whose flags were not all sent.
module cluster_readout_serializer #(
    parameter int NVPF         = 768,
    parameter int ADDR_W       = 10,
    parameter int CNT_W        = 11,
    parameter int MAX_CLUSTERS = 16,
    parameter int NSEG         = 8
) (
    input  logic              clock4x,
    input  logic              reset_n,
    input  logic [NVPF-1:0]   vpfs_i,
    input  logic              load_i,
    output logic              busy_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              last_o,
    output logic [CNT_W-1:0]  sent_cnt_o,
    output logic              overflow_o,
    output logic              done_o
);

    localparam int SEG_W  = NVPF / NSEG;
    localparam int SEG_IW = (SEG_W > 1) ? $clog2(SEG_W) : 1;
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_CLUSTERS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_CLUSTERS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SCAN = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [NVPF-1:0]     mask_q, mask_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                valid_q, valid_d;
    logic                last_q, last_d;
    logic                busy_q, busy_d;
    logic [CNT_W-1:0]    sent_cnt_q, sent_cnt_d;
    logic                overflow_q, overflow_d;
    logic                done_q, done_d;

    logic                xfer;
    logic [NVPF-1:0]     mask_clr;
    logic [NVPF-1:0]     enc_in;
    logic [NVPF-1:0]     enc_rem;
    logic [ADDR_W-1:0]   enc_addr;
    logic                enc_any;
    logic                enc_others;
    logic [CNT_W-1:0]    cnt_inc;

    // Saturating increment so the sent counter can never wrap past the cap.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c >= MAX_CNT) ? MAX_CNT : c + CNT_W'(1);
    endfunction

    // Lowest set bit of one segment, returned as {hit, index}.
    function automatic logic [SEG_IW:0] seg_lowest(input logic [SEG_W-1:0] seg);
        logic [SEG_IW:0] r;
        r = '0;
        for (int b = SEG_W - 1; b >= 0; b--) begin
            if (seg[b]) r = {1'b1, SEG_IW'(b)};
        end
        return r;
    endfunction

    assign xfer    = (state_q == SCAN) && valid_q && ready_i;
    assign cnt_inc = sat_inc(sent_cnt_q);

    // Mask with the currently presented address removed; the encoder looks
    // ahead through it on a transfer so the next address appears next cycle.
    always_comb begin
        mask_clr         = mask_q;
        mask_clr[addr_q] = 1'b0;
        enc_in           = xfer ? mask_clr : mask_q;
    end

    // Segmented priority encode: every segment finds its lowest set bit,
    // the lowest non-empty segment wins (scanned high to low so it overrides).
    always_comb begin
        logic [SEG_IW:0] seg_res;
        enc_any  = 1'b0;
        enc_addr = '0;
        seg_res  = '0;
        for (int s = NSEG - 1; s >= 0; s--) begin
            seg_res = seg_lowest(enc_in[s*SEG_W +: SEG_W]);
            if (seg_res[SEG_IW]) begin
                enc_any  = 1'b1;
                enc_addr = ADDR_W'(s * SEG_W) + ADDR_W'(seg_res[SEG_IW-1:0]);
            end
        end
    end

    // Any flag beyond the one about to be presented decides last_o.
    always_comb begin
        enc_rem           = enc_in;
        enc_rem[enc_addr] = 1'b0;
        enc_others        = |enc_rem;
    end

    // Next-state and output logic; everything holds unless a state acts.
    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        addr_d     = addr_q;
        valid_d    = valid_q;
        last_d     = last_q;
        sent_cnt_d = sent_cnt_q;
        overflow_d = overflow_q;

        unique case (state_q)
            IDLE: begin
                if (load_i) begin
                    mask_d     = vpfs_i;
                    sent_cnt_d = '0;
                    overflow_d = 1'b0;
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                addr_d  = enc_addr;
                valid_d = enc_any;
                last_d  = enc_any && (!enc_others || (sent_cnt_q == LAST_CNT));
                state_d = enc_any ? SCAN : DONE;
            end
            SCAN: begin
                if (xfer) begin
                    mask_d     = mask_clr;
                    sent_cnt_d = cnt_inc;
                    if (last_q) begin
                        valid_d    = 1'b0;
                        last_d     = 1'b0;
                        overflow_d = |mask_clr;
                        state_d    = DONE;
                    end else begin
                        addr_d  = enc_addr;
                        valid_d = 1'b1;
                        last_d  = !enc_others || (cnt_inc == LAST_CNT);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State and output registers; reset clears every flop.
    always_ff @(posedge clock4x or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            mask_q     <= '0;
            addr_q     <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            busy_q     <= 1'b0;
            sent_cnt_q <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            addr_q     <= addr_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
            busy_q     <= busy_d;
            sent_cnt_q <= sent_cnt_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
        end
    end

    assign busy_o     = busy_q;
    assign addr_o     = addr_q;
    assign valid_o    = valid_q;
    assign last_o     = last_q;
    assign sent_cnt_o = sent_cnt_q;
    assign overflow_o = overflow_q;
    assign done_o     = done_q;

endmodule
